// File: rtl/servo_frame_scheduler.sv
// Multi-channel servo set-point sequencer: slews each joint toward its target once per
// frame and publishes all rise/fall counts together at the frame boundary.
module servo_frame_scheduler #(
  parameter int NUM_CH       = 4,
  parameter int PERIOD_TICKS = 1000000,
  parameter int MIN_W        = 50000,
  parameter int MAX_W        = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [3:0]            cmd_ch,
  input  logic [31:0]           cmd_target,
  input  logic [15:0]           cfg_step,
  output logic [32*NUM_CH-1:0]  rise_bus,
  output logic [32*NUM_CH-1:0]  fall_bus,
  output logic                  frame_tick,
  output logic                  settled
);

  // state  | meaning
  // IDLE   | accepting commands, waiting for frame_tick
  // UPDATE | slewing channel k toward its target, one channel per cycle
  // COMMIT | copying every cur[] to the output buses in a single cycle
  typedef enum logic [1:0] {IDLE, UPDATE, COMMIT} state_t;

  localparam int          KW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [31:0] PERIOD = 32'(PERIOD_TICKS);
  localparam logic [31:0] PMAX   = 32'(PERIOD_TICKS - 1);
  localparam logic [31:0] WMIN   = 32'(MIN_W);
  localparam logic [31:0] WMAX   = 32'(MAX_W);
  localparam logic [31:0] CENTER = 32'((MIN_W + MAX_W) / 2);

  state_t             state, state_d;
  logic [KW-1:0]      k, k_d;
  logic [31:0]        cnt;
  logic [31:0]        cur   [NUM_CH];
  logic [31:0]        tgt   [NUM_CH];
  logic [31:0]        cur_d [NUM_CH];
  logic [31:0]        tgt_d [NUM_CH];
  logic [31:0]        clamped, k_cur, k_tgt, stepped;
  logic signed [32:0] diff, mag;
  logic               settled_d, commit;

  assign frame_tick = (cnt == PMAX);

  always_comb begin
    if (cmd_target < WMIN)      clamped = WMIN;
    else if (cmd_target > WMAX) clamped = WMAX;
    else                        clamped = cmd_target;
  end

  // Bounded slew for the channel currently selected by k.
  always_comb begin
    k_cur = cur[0];
    k_tgt = tgt[0];
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(k) == i) begin
        k_cur = cur[i];
        k_tgt = tgt[i];
      end
    end
    diff = $signed({1'b0, k_tgt}) - $signed({1'b0, k_cur});
    mag  = diff[32] ? -diff : diff;
    if (cfg_step == 16'd0 || mag <= $signed({17'd0, cfg_step})) stepped = k_tgt;
    else if (diff[32])                                           stepped = k_cur - {16'd0, cfg_step};
    else                                                         stepped = k_cur + {16'd0, cfg_step};
  end

  always_comb begin
    state_d   = state;
    k_d       = k;
    cmd_ready = (state == IDLE);
    commit    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      cur_d[i] = cur[i];
      tgt_d[i] = tgt[i];
    end
    case (state)
      IDLE: begin
        if (frame_tick) begin
          state_d = UPDATE;
          k_d     = '0;
        end
      end
      UPDATE: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (int'(k) == i) cur_d[i] = stepped;
        end
        if (int'(k) == NUM_CH - 1) state_d = COMMIT;
        else                       k_d     = k + KW'(1);
      end
      COMMIT: begin
        commit  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (cmd_valid && cmd_ready) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (int'(cmd_ch) == i) tgt_d[i] = clamped;
      end
    end
    // Evaluated on next-state values so settled drops the cycle right after a retarget.
    settled_d = (state_d == IDLE);
    for (int i = 0; i < NUM_CH; i++) begin
      if (cur_d[i] != tgt_d[i]) settled_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      state   <= IDLE;
      k       <= '0;
      settled <= 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        cur[i]             <= CENTER;
        tgt[i]             <= CENTER;
        rise_bus[32*i +: 32] <= CENTER;
        fall_bus[32*i +: 32] <= PERIOD - CENTER;
      end
    end else begin
      cnt     <= (cnt == PMAX) ? '0 : cnt + 32'd1;
      state   <= state_d;
      k       <= k_d;
      settled <= settled_d;
      for (int i = 0; i < NUM_CH; i++) begin
        cur[i] <= cur_d[i];
        tgt[i] <= tgt_d[i];
        if (commit) begin
          rise_bus[32*i +: 32] <= cur[i];
          fall_bus[32*i +: 32] <= PERIOD - cur[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_servo_frame_scheduler.sv
// Directed bench for servo_frame_scheduler; a per-frame scoreboard of expected rise
// values is filled at each frame_tick and drained when the commit becomes visible.
module tb_servo_frame_scheduler;
  localparam int NCH = 4, PER = 100, MINW = 10, MAXW = 50, CEN = 30;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [3:0]        cmd_ch = '0;
  logic [31:0]       cmd_target = '0;
  logic [15:0]       cfg_step = '0;
  logic [32*NCH-1:0] rise_bus, fall_bus;
  logic              frame_tick, settled;

  int          n_cmp = 0, n_err = 0;
  logic [31:0] m_cur [NCH];
  logic [31:0] m_tgt [NCH];
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  servo_frame_scheduler #(.NUM_CH(NCH), .PERIOD_TICKS(PER), .MIN_W(MINW), .MAX_W(MAXW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_target(cmd_target), .cfg_step(cfg_step),
    .rise_bus(rise_bus), .fall_bus(fall_bus), .frame_tick(frame_tick), .settled(settled)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] clampw(input logic [31:0] v);
    if (v < MINW) return MINW;
    if (v > MAXW) return MAXW;
    return v;
  endfunction

  function automatic logic [31:0] step_to(input logic [31:0] c, input logic [31:0] t,
                                          input logic [15:0] s);
    if (s == 0) return t;
    if (t > c) return (t - c <= s) ? t : c + s;
    return (c - t <= s) ? t : c - s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_cur[i] = CEN;
      m_tgt[i] = CEN;
    end
    exp_q.delete();
  endtask

  task automatic check_lanes(input string tag, input logic [31:0] r);
    for (int i = 0; i < NCH; i++) begin
      chk($sformatf("%s_rise%0d", tag, i), rise_bus[32*i +: 32], r);
      chk($sformatf("%s_fall%0d", tag, i), fall_bus[32*i +: 32], PER - r);
    end
  endtask

  task automatic wait_tick();
    int n = 0;
    while (frame_tick !== 1'b1 && n < PER + 10) begin
      cyc();
      n++;
    end
    chk("tick_seen", frame_tick, 1);
  endtask

  task automatic push_frame();
    for (int i = 0; i < NCH; i++) begin
      m_cur[i] = step_to(m_cur[i], m_tgt[i], cfg_step);
      exp_q.push_back(m_cur[i]);
    end
  endtask

  task automatic check_frame(input string tag);
    logic [31:0] e;
    logic        s_exp = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL %s_queue observed=empty expected=entry", tag);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("%s_rise%0d", tag, i), rise_bus[32*i +: 32], e);
        chk($sformatf("%s_fall%0d", tag, i), fall_bus[32*i +: 32], PER - e);
      end
      if (m_cur[i] != m_tgt[i]) s_exp = 1'b0;
    end
    chk({tag, "_settled"}, settled, s_exp);
  endtask

  // Waits for a tick, then checks the busy window and the committed values NUM_CH+2 later.
  task automatic run_frame(input string tag);
    wait_tick();
    push_frame();
    cyc();
    for (int j = 0; j < 5; j++) begin
      chk({tag, "_busy_ready"}, cmd_ready, 0);
      cyc();
    end
    chk({tag, "_idle_ready"}, cmd_ready, 1);
    check_frame(tag);
  endtask

  task automatic send_cmd(input logic [3:0] ch, input logic [31:0] t);
    int n = 0;
    cmd_ch = ch;
    cmd_target = t;
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    chk("send_ready", cmd_ready, 1);
    cyc();
    cmd_valid = 1'b0;
    if (ch < NCH) m_tgt[ch] = clampw(t);
  endtask

  initial begin
    logic [31:0] prev;
    model_reset();

    // 1: reset state, tick timing, idle frames at centre
    cyc();
    cyc();
    check_lanes("rst", CEN);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_settled", settled, 1);
    chk("rst_tick", frame_tick, 0);
    reset = 1'b1;
    repeat (98) cyc();
    chk("tick_before_100", frame_tick, 0);
    cyc();
    chk("tick_at_100", frame_tick, 1);
    run_frame("t1a");
    repeat (94) cyc();
    chk("tick_at_200", frame_tick, 1);
    run_frame("t1b");

    // 2: bounded slew of ch1 to 42 in steps of 4
    cfg_step = 16'd4;
    send_cmd(4'd1, 32'd42);
    chk("t2_settled_drop", settled, 0);
    run_frame("t2f1");
    run_frame("t2f2");
    run_frame("t2f3");

    // 3: direct jump with clamping at both ends; out-of-range channel discarded
    cfg_step = 16'd0;
    send_cmd(4'd2, 32'd5);
    run_frame("t3lo");
    send_cmd(4'd2, 32'd70);
    send_cmd(4'd9, 32'd12);
    run_frame("t3hi");

    // 4: command held from tick+1 waits out UPDATE/COMMIT, lands next frame
    wait_tick();
    push_frame();
    cyc();
    cmd_ch = 4'd3;
    cmd_target = 32'd20;
    cmd_valid = 1'b1;
    for (int j = 0; j < 5; j++) begin
      chk("t4_hold_ready_low", cmd_ready, 0);
      cyc();
    end
    chk("t4_hold_ready_high", cmd_ready, 1);
    check_frame("t4_prev");
    cyc();
    cmd_valid = 1'b0;
    m_tgt[3] = 32'd20;
    chk("t4_settled_drop", settled, 0);
    run_frame("t4_apply");

    // 5: command in the tick cycle is used by that frame, visible exactly 6 cycles later
    wait_tick();
    prev = m_cur[0];
    cmd_ch = 4'd0;
    cmd_target = 32'd40;
    cmd_valid = 1'b1;
    m_tgt[0] = 32'd40;
    push_frame();
    cyc();
    cmd_valid = 1'b0;
    repeat (4) cyc();
    chk("t5_rise0_at_5", rise_bus[31:0], prev);
    cyc();
    check_frame("t5");

    // 6: reset in the middle of UPDATE discards everything
    cfg_step = 16'd4;
    send_cmd(4'd0, 32'd50);
    wait_tick();
    repeat (3) cyc();
    reset = 1'b0;
    #1;
    check_lanes("t6_rst", CEN);
    chk("t6_rst_settled", settled, 1);
    chk("t6_rst_ready", cmd_ready, 1);
    chk("t6_rst_tick", frame_tick, 0);
    model_reset();
    cyc();
    cyc();
    reset = 1'b1;
    repeat (98) cyc();
    chk("t6_tick_before_100", frame_tick, 0);
    cyc();
    chk("t6_tick_at_100", frame_tick, 1);
    run_frame("t6_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
